// File: rtl/register_file_pkg.sv
// Shared constants and types for the 16 x 16-bit register file.
//   DATA_W    : register width in bits
//   NUM_REGS  : number of architectural registers (R0 is hard-wired zero)
//   ADDR_W    : register index width
//   reg_idx_t : register index type
package register_file_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/register_file_if.sv
// Decode/execute-side bus of the register file.
//   SrcReg1/SrcReg2   : read-port indices
//   DstReg/WriteReg   : write index and write enable
//   DstData           : write data
//   SrcData1/SrcData2 : combinational read data
// master = decode stage driving the file, slave = the register file itself.
interface register_file_if;
  import register_file_pkg::*;

  reg_idx_t  SrcReg1;
  reg_idx_t  SrcReg2;
  reg_idx_t  DstReg;
  logic      WriteReg;
  reg_data_t DstData;
  reg_data_t SrcData1;
  reg_data_t SrcData2;

  modport master (
    output SrcReg1, SrcReg2, DstReg, WriteReg, DstData,
    input  SrcData1, SrcData2
  );

  modport slave (
    input  SrcReg1, SrcReg2, DstReg, WriteReg, DstData,
    output SrcData1, SrcData2
  );
endinterface

// File: rtl/register16.sv
// Single 16-bit storage register with synchronous clear and write enable.
//   clk : rising-edge clock
//   rst : synchronous active-high clear (wins over we)
//   we  : load d on the next rising edge
//   d   : write data
//   q   : stored value
module register16
  import register_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_data_t d,
  output reg_data_t q
);

  reg_data_t data_d;
  reg_data_t data_q;

  always_comb begin
    data_d = data_q;
    if (we) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/register_file.sv
// Sixteen-entry, 16-bit register file: two combinational read ports, one
// synchronous write port, R0 hard-wired to zero, write-to-read bypass.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears R1..R15
//   rf  : register_file_if.slave bus (indices, write enable/data, read data)
module register_file
  import register_file_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  rf
);

  reg_data_t            reg_q [NUM_REGS];
  logic [NUM_REGS-1:1]  we_vec;
  logic                 wr_live;

  // R0 has no storage; the write decoder never enables it.
  assign reg_q[0] = '0;

  // A write is only "live" for bypass purposes when it will actually commit.
  assign wr_live = rf.WriteReg && !rst && (rf.DstReg != '0);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
    assign we_vec[i] = rf.WriteReg && (rf.DstReg == reg_idx_t'(i));

    register16 u_reg (
      .clk (clk),
      .rst (rst),
      .we  (we_vec[i]),
      .d   (rf.DstData),
      .q   (reg_q[i])
    );
  end

  // Bypass presents the in-flight write before the edge so the output does
  // not change when the stored value takes over after the edge.
  always_comb begin
    rf.SrcData1 = reg_q[rf.SrcReg1];
    if (wr_live && (rf.DstReg == rf.SrcReg1)) begin
      rf.SrcData1 = rf.DstData;
    end
  end

  always_comb begin
    rf.SrcData2 = reg_q[rf.SrcReg2];
    if (wr_live && (rf.DstReg == rf.SrcReg2)) begin
      rf.SrcData2 = rf.DstData;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed test-plan steps with literal
// expectations plus randomized traffic checked against an array model.
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic rst;
  register_file_if rf_if ();

  register_file dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [15:0] mdl [16];

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
  end

  // Architectural model: commit on the edge, reset clears everything.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    end else if (rf_if.WriteReg && rf_if.DstReg != 4'd0) begin
      mdl[rf_if.DstReg] = rf_if.DstData;
    end
  end

  function automatic logic [15:0] exp_rd(input logic [3:0] idx);
    if (idx == 4'd0) return 16'h0000;
    if (!rst && rf_if.WriteReg && rf_if.DstReg == idx) return rf_if.DstData;
    return mdl[idx];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_p1", rf_if.SrcData1, exp_rd(rf_if.SrcReg1));
      chk("model_p2", rf_if.SrcData2, exp_rd(rf_if.SrcReg2));
    end
  end

  task automatic drive(input logic r, input logic we, input logic [3:0] dst,
                       input logic [15:0] data, input logic [3:0] s1, input logic [3:0] s2);
    rst              = r;
    rf_if.WriteReg   = we;
    rf_if.DstReg     = dst;
    rf_if.DstData    = data;
    rf_if.SrcReg1    = s1;
    rf_if.SrcReg2    = s2;
  endtask

  // Move to mid-cycle (after negedge) for literal checks.
  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'd0, 16'h00FF, 4'd0, 4'd0);
    // Test 1: reset with data on the bus but no write
    edge_();
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h00FF, 4'(i), 4'(15 - i));
      mid();
      chk("rst_p1", rf_if.SrcData1, 16'h0000);
      chk("rst_p2", rf_if.SrcData2, 16'h0000);
      edge_();
    end

    // Test 2: write R2, bypass then stored
    drive(1'b0, 1'b1, 4'd2, 16'h03FE, 4'd2, 4'd0);
    mid();
    chk("r2_bypass", rf_if.SrcData1, 16'h03FE);
    edge_();
    drive(1'b0, 1'b0, 4'd2, 16'h03FE, 4'd2, 4'd0);
    mid();
    chk("r2_stored", rf_if.SrcData1, 16'h03FE);
    edge_();

    // Test 3: write R13 via port 2, then WriteReg=0 with changed data
    drive(1'b0, 1'b1, 4'd13, 16'hDDDD, 4'd0, 4'd13);
    mid();
    chk("r13_bypass", rf_if.SrcData2, 16'hDDDD);
    edge_();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 4'd13, 16'hDDFF, 4'd0, 4'd13);
      mid();
      chk("r13_hold", rf_if.SrcData2, 16'hDDDD);
      edge_();
    end

    // Test 4: writes to R0 discarded
    drive(1'b0, 1'b1, 4'd0, 16'h00FF, 4'd0, 4'd0);
    mid();
    chk("r0_during_p1", rf_if.SrcData1, 16'h0000);
    chk("r0_during_p2", rf_if.SrcData2, 16'h0000);
    edge_();
    drive(1'b0, 1'b0, 4'd0, 16'h00FF, 4'd0, 4'd0);
    mid();
    chk("r0_after_p1", rf_if.SrcData1, 16'h0000);
    chk("r0_after_p2", rf_if.SrcData2, 16'h0000);
    edge_();

    // Test 5: dual read, then reset beats a concurrent write
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd13, 4'd13);
    mid();
    chk("dual_p1", rf_if.SrcData1, 16'hDDDD);
    chk("dual_p2", rf_if.SrcData2, 16'hDDDD);
    edge_();
    drive(1'b1, 1'b1, 4'd5, 16'h1234, 4'd5, 4'd13);
    mid();
    chk("rstwr_nobyp", rf_if.SrcData1, 16'h0000);
    chk("rstwr_stored", rf_if.SrcData2, 16'hDDDD);
    edge_();
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd2);
    mid();
    chk("post_rst_r5", rf_if.SrcData1, 16'h0000);
    chk("post_rst_r2", rf_if.SrcData2, 16'h0000);
    edge_();
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd13, 4'd13);
    mid();
    chk("post_rst_r13", rf_if.SrcData1, 16'h0000);
    edge_();

    // Test 6: exhaustive write/read
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i), 16'(16'h1111 * i), 4'd0, 4'd0);
      edge_();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'(i), 4'(i));
      mid();
      chk("exh_p1", rf_if.SrcData1, 16'(16'h1111 * i));
      chk("exh_p2", rf_if.SrcData2, 16'(16'h1111 * i));
      edge_();
    end

    // Randomized traffic; occasionally change DstData mid-cycle to exercise
    // the bypass following the data.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
            4'($urandom_range(0, 15)), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        rf_if.SrcReg1 = rf_if.DstReg;
      end
      if ($urandom_range(0, 3) == 0) begin
        rf_if.SrcReg2 = rf_if.DstReg;
      end
      @(negedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        rf_if.DstData = 16'($urandom);
        #1;
        chk("late_p1", rf_if.SrcData1, exp_rd(rf_if.SrcReg1));
        chk("late_p2", rf_if.SrcData2, exp_rd(rf_if.SrcReg2));
      end
      edge_();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
